// File: rtl/im_loader.sv
// im_loader: boot-time byte-stream to instruction-memory word writer.
// Ports:
//   clk, reset_n      - rising-edge clock, synchronous active-low reset
//   start             - pulse to begin a load (honoured in IDLE/DONE/ERROR)
//   byte_valid/_data  - incoming stream byte, accepted when byte_ready is high
//   byte_ready        - loader can take a byte this cycle
//   we/waddr/wdata    - one-cycle word write to instruction memory
//   busy              - load in progress (holds the core in reset)
//   done/error        - sticky outcome of the last load
module im_loader #(
    parameter logic [31:0] IM_START_ADDRESS = 32'h0000_3000,
    parameter int unsigned IM_SIZE          = 4096,
    parameter int unsigned TIMEOUT          = 1000000,
    parameter int unsigned CNT_WIDTH        = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE, S_ERROR} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             bcnt_q, bcnt_d;
    logic [23:0]            shift_q, shift_d;
    logic [31:0]            len_q, len_d;
    logic [31:0]            widx_q, widx_d;
    logic [CNT_WIDTH-1:0]   tcnt_q, tcnt_d;
    logic                   we_q, we_d;
    logic [31:0]            waddr_q, waddr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   accept;
    logic [31:0]            word;

    assign busy       = (state_q == S_LEN) || (state_q == S_DATA);
    assign byte_ready = busy;
    assign done       = state_q == S_DONE;
    assign error      = state_q == S_ERROR;
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign accept     = byte_valid && byte_ready;
    // Only three bytes are buffered; the fourth completes the word directly.
    assign word       = {shift_q, byte_data};

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        len_d   = len_q;
        widx_d  = widx_q;
        tcnt_d  = tcnt_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN;
                    bcnt_d  = '0;
                    tcnt_d  = '0;
                end
            end
            S_LEN, S_DATA: begin
                if (accept) begin
                    tcnt_d  = '0;
                    bcnt_d  = bcnt_q + 2'd1;
                    shift_d = {shift_q[15:0], byte_data};
                    if (bcnt_q == 2'd3) begin
                        if (state_q == S_LEN) begin
                            len_d   = word;
                            widx_d  = '0;
                            state_d = word == 32'd0 ? S_DONE : word > IM_SIZE ? S_ERROR : S_DATA;
                        end else begin
                            we_d    = 1'b1;
                            waddr_d = IM_START_ADDRESS + (widx_q << 2);
                            wdata_d = word;
                            widx_d  = widx_q + 32'd1;
                            if (widx_q == len_q - 32'd1) state_d = S_DONE;
                        end
                    end
                end else if (tcnt_q == CNT_WIDTH'(TIMEOUT - 1)) begin
                    // An accepted byte on this edge would have taken the branch above.
                    state_d = S_ERROR;
                end else begin
                    tcnt_d = tcnt_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            shift_q <= '0;
            len_q   <= '0;
            widx_q  <= '0;
            tcnt_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            len_q   <= len_d;
            widx_q  <= widx_d;
            tcnt_q  <= tcnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
Boot-time writer for the instruction memory. It consumes a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and issues single-cycle word writes to the instruction-memory write port, starting at IM_START_ADDRESS. While it runs, busy holds the core in reset. Sits between the byte-stream front end (UART/debug link) and the instruction memory.

Parameters:
IM_START_ADDRESS, 32'h0000_3000, byte address of instruction-memory word 0
IM_SIZE, 4096, instruction-memory capacity in words; maximum load length
TIMEOUT, 1000000, idle cycles allowed between accepted bytes while loading
CNT_WIDTH, 20, width of the timeout counter; must satisfy 2^CNT_WIDTH > TIMEOUT

Ports:
clk  input  1  system clock; all logic on the rising edge
reset_n  input  1  synchronous, active-low reset
start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR
byte_valid  input  1  byte_data is valid this cycle
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this cycle
we  output  1  instruction-memory write strobe, one cycle per word
waddr  output  32  byte address of the write, word aligned
wdata  output  32  word to write
busy  output  1  load in progress; core held in reset
done  output  1  last load completed successfully; sticky
error  output  1  last load failed (length or timeout); sticky

Behaviour:
- Reset (reset_n=0 at a clock edge): state IDLE, byte counter 0, word index 0, timeout counter 0. All outputs are 0: byte_ready, we, waddr, wdata, busy, done and error. Reset mid-load abandons the load, and no further we pulses occur.
- A byte is accepted when byte_valid && byte_ready at a rising edge. byte_valid without byte_ready has no effect.
- States:
  - IDLE: byte_ready=0. start moves to LEN and clears done and error.
  - LEN: byte_ready=1 and busy=1. Collect 4 bytes, first byte = bits 31:24, into length N.
    - On the 4th accepted byte: N==0 goes to DONE; N>IM_SIZE goes to ERROR; otherwise go to DATA with word index 0.
  - DATA: byte_ready=1 and busy=1. Collect 4 bytes per word, big-endian.
    - The cycle after the 4th byte of word k is accepted: we=1 for exactly one cycle, waddr=IM_START_ADDRESS+4*k (32-bit wrap-free since N<=IM_SIZE), wdata=assembled word.
    - After word N-1 is accepted, go to DONE. Its we pulse coincides with the first DONE cycle.
  - DONE: busy=0, byte_ready=0, done=1 held. start restarts at LEN.
  - ERROR: busy=0, byte_ready=0, error=1 held, no we. start restarts at LEN.
- start is ignored in LEN and DATA.
- Timeout counter: cleared on every accepted byte and on entry to LEN. It increments each cycle in LEN/DATA without an accepted byte. When it reaches TIMEOUT, go to ERROR. A partially assembled word is discarded, and already-written words stay written.
- Simultaneous events: reset_n=0 dominates everything. A byte accepted on the same edge the timeout is reached counts as accepted, and the timeout does not fire.
- waddr and wdata hold their last values when we=0.
- busy is combinationally (state==LEN || state==DATA).
- Throughput: one byte per cycle sustained; one word every 4 cycles with no stall.

Test Plan:
1. Reset, start, stream 00 00 00 02 | 12 34 56 78 | 9A BC DE F0 back-to-back -> we pulses: waddr=0x3000 wdata=0x12345678, then waddr=0x3004 wdata=0x9ABCDEF0; done=1, busy=0, exactly 2 we pulses.
2. Length 00 00 00 00 -> DONE after the 4th byte, no we, done=1. Length 00 00 10 01 (4097) -> error=1, no we, byte_ready=0.
3. TIMEOUT=16, N=1, send 2 data bytes then idle 16 cycles -> error=1 on cycle 16. Idle 15 cycles then a byte -> no error.
4. Randomly gapped byte_valid and a start pulse mid-DATA -> start ignored, words identical to scenario 1, one we per word.
5. Assert reset_n=0 after 5 data bytes of an N=3 load -> all outputs 0 next cycle, no further we. A subsequent start and full load completes normally.
6. After DONE, start a second load with N=1 word 0xDEADBEEF -> done clears on start, we at waddr=0x3000 wdata=0xDEADBEEF, done=1.
